// File: rtl/multicycle_seq_if.sv
// -----------------------------------------------------------------------------
// multicycle_seq_if
//   Bundles the sequencer's run/decode inputs, the memory handshake and the
//   datapath control strobes.
//
//   master : sequencer side (drives strobes, status, counter)
//   slave  : datapath / memory side (drives run, opcode, br_taken,
//            mem_ready, clear_trap)
//
//   Signals:
//     run        level, permits execution, sampled at instruction boundaries
//     opcode     IR[6:0], valid from DECODE onward
//     br_taken   branch outcome, valid in EXEC
//     mem_ready  memory completes the current request this cycle
//     clear_trap leaves TRAP
//     mem_req / mem_we / addr_sel          memory port control
//     ir_we / mdr_we / rf_we / pc_we       load strobes
//     pc_sel     0 = PC+4, 1 = branch target
//     retire     one pulse per completed instruction
//     busy / trap / err_code / state       status
//     instret    retired-instruction count
// -----------------------------------------------------------------------------
interface multicycle_seq_if #(
    parameter int INSTRET_W = 32
);
    logic                 run;
    logic [6:0]           opcode;
    logic                 br_taken;
    logic                 mem_ready;
    logic                 clear_trap;

    logic                 mem_req;
    logic                 mem_we;
    logic                 addr_sel;
    logic                 ir_we;
    logic                 mdr_we;
    logic                 rf_we;
    logic                 pc_we;
    logic                 pc_sel;
    logic                 retire;
    logic                 busy;
    logic                 trap;
    logic [1:0]           err_code;
    logic [2:0]           state;
    logic [INSTRET_W-1:0] instret;

    modport master (
        input  run, opcode, br_taken, mem_ready, clear_trap,
        output mem_req, mem_we, addr_sel, ir_we, mdr_we, rf_we, pc_we, pc_sel,
               retire, busy, trap, err_code, state, instret
    );

    modport slave (
        output run, opcode, br_taken, mem_ready, clear_trap,
        input  mem_req, mem_we, addr_sel, ir_we, mdr_we, rf_we, pc_we, pc_sel,
               retire, busy, trap, err_code, state, instret
    );
endinterface

// File: rtl/multicycle_seq.sv
// -----------------------------------------------------------------------------
// multicycle_seq
//   Multi-cycle sequencer for the RV32I datapath. Steps one instruction through
//   FETCH, DECODE, EXEC, MEM and WB so fetch and load/store share one memory
//   port. Adds a memory-handshake timeout, an illegal-opcode trap and a
//   retired-instruction counter.
//
//   Parameters:
//     TIMEOUT   cycles mem_req may wait for mem_ready before trapping (0 = off)
//     INSTRET_W width of the retired-instruction counter
//
//   Ports:
//     clk  system clock, rising edge
//     rst  asynchronous, active-high reset
//     bus  multicycle_seq_if.master (handshake, strobes, status, instret)
//
//   Strobes are Mealy outputs of the state register and mem_ready.
// -----------------------------------------------------------------------------
module multicycle_seq #(
    parameter int TIMEOUT   = 16,
    parameter int INSTRET_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    multicycle_seq_if.master   bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        C_R      = 3'd0,
        C_I      = 3'd1,
        C_LOAD   = 3'd2,
        C_STORE  = 3'd3,
        C_LUI    = 3'd4,
        C_BRANCH = 3'd5
    } cls_e;

    typedef enum logic [1:0] {
        E_NONE    = 2'd0,
        E_TIMEOUT = 2'd1,
        E_ILLEGAL = 2'd2
    } err_e;

    localparam bit                TMO_EN   = (TIMEOUT > 0);
    localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // Count of wait cycles already spent when the current one is the last allowed.
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TMO_EN ? TIMEOUT - 1 : 0);

    state_e                state_q, state_d;
    cls_e                  cls_q, cls_d;
    err_e                  err_q, err_d;
    logic [CNT_W-1:0]      tmo_q, tmo_d;
    logic [INSTRET_W-1:0]  instret_q;

    logic mem_req, mem_we, addr_sel, ir_we, mdr_we, rf_we, pc_we, pc_sel, retire;
    logic tmo_hit;
    state_e boundary;

    assign tmo_hit  = TMO_EN && (tmo_q == CNT_LAST);
    // Next state after an instruction completes; run is only honoured here.
    assign boundary = bus.run ? S_FETCH : S_IDLE;

    // NOTE: every output and next-state variable gets a default before the case,
    // so no path through this block can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
        err_d    = err_q;
        tmo_d    = '0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ir_we    = 1'b0;
        mdr_we   = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 1'b0;
        retire   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.run) state_d = S_FETCH;
            end

            S_FETCH: begin
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                    err_d   = E_TIMEOUT;
                end else if (TMO_EN) begin
                    tmo_d = tmo_q + CNT_W'(1);
                end
            end

            S_DECODE: begin
                state_d = S_EXEC;
                unique case (bus.opcode)
                    7'b0110011: cls_d = C_R;
                    7'b0010011: cls_d = C_I;
                    7'b0000011: cls_d = C_LOAD;
                    7'b0100011: cls_d = C_STORE;
                    7'b0110111: cls_d = C_LUI;
                    7'b1100011: cls_d = C_BRANCH;
                    default: begin
                        state_d = S_TRAP;
                        err_d   = E_ILLEGAL;
                    end
                endcase
            end

            S_EXEC: begin
                unique case (cls_q)
                    C_BRANCH: begin
                        pc_we   = 1'b1;
                        pc_sel  = bus.br_taken;
                        retire  = 1'b1;
                        state_d = boundary;
                    end
                    C_LOAD, C_STORE: state_d = S_MEM;
                    default:         state_d = S_WB;
                endcase
            end

            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (cls_q == C_STORE);
                if (bus.mem_ready) begin
                    if (cls_q == C_STORE) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = boundary;
                    end else begin
                        mdr_we  = 1'b1;
                        state_d = S_WB;
                    end
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                    err_d   = E_TIMEOUT;
                end else if (TMO_EN) begin
                    tmo_d = tmo_q + CNT_W'(1);
                end
            end

            S_WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_d = boundary;
            end

            S_TRAP: begin
                if (bus.clear_trap) begin
                    state_d = S_IDLE;
                    err_d   = E_NONE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cls_q     <= C_R;
            err_q     <= E_NONE;
            tmo_q     <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            if (retire) instret_q <= instret_q + INSTRET_W'(1);
        end
    end

    assign bus.mem_req  = mem_req;
    assign bus.mem_we   = mem_we;
    assign bus.addr_sel = addr_sel;
    assign bus.ir_we    = ir_we;
    assign bus.mdr_we   = mdr_we;
    assign bus.rf_we    = rf_we;
    assign bus.pc_we    = pc_we;
    assign bus.pc_sel   = pc_sel;
    assign bus.retire   = retire;
    assign bus.busy     = (state_q != S_IDLE) && (state_q != S_TRAP);
    assign bus.trap     = (state_q == S_TRAP);
    assign bus.err_code = err_q;
    assign bus.state    = state_q;
    assign bus.instret  = instret_q;

endmodule

// File: tb/tb_multicycle_seq.sv
// -----------------------------------------------------------------------------
// tb_multicycle_seq
//   Directed self-checking bench for multicycle_seq (TIMEOUT=16, INSTRET_W=4).
//   Each scenario fills a per-cycle plan (inputs + expected state/strobes),
//   replays it, then compares what was captured against the plan.
//   Strobe vector order:
//     {mem_req, mem_we, addr_sel, ir_we, mdr_we, rf_we, pc_we, pc_sel,
//      retire, busy, trap}
// -----------------------------------------------------------------------------
module tb_multicycle_seq;

    localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
                           MEM  = 3'd4, WB    = 3'd5, TRAP   = 3'd7;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    localparam logic [10:0] O_NONE        = 11'b00000000000;
    localparam logic [10:0] O_BUSY        = 11'b00000000010;
    localparam logic [10:0] O_FETCH_RDY   = 11'b10010000010;
    localparam logic [10:0] O_FETCH_WAIT  = 11'b10000000010;
    localparam logic [10:0] O_MEM_LD_WAIT = 11'b10100000010;
    localparam logic [10:0] O_MEM_LD_RDY  = 11'b10101000010;
    localparam logic [10:0] O_MEM_ST_WAIT = 11'b11100000010;
    localparam logic [10:0] O_MEM_ST_RDY  = 11'b11100010110;
    localparam logic [10:0] O_WB          = 11'b00000110110;
    localparam logic [10:0] O_BR_T        = 11'b00000011110;
    localparam logic [10:0] O_BR_N        = 11'b00000010110;
    localparam logic [10:0] O_TRAP        = 11'b00000000001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_seq_if #(.INSTRET_W(4)) bus ();

    multicycle_seq #(.TIMEOUT(16), .INSTRET_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passed = 0;

    logic        pl_run [24];
    logic        pl_rdy [24];
    logic        pl_brt [24];
    logic        pl_clr [24];
    logic [2:0]  exp_st [24];
    logic [10:0] exp_o  [24];
    logic [2:0]  obs_st [24];
    logic [10:0] obs_o  [24];
    logic [3:0]  obs_cnt[24];
    logic [1:0]  obs_err[24];

    function automatic logic [10:0] outs();
        return {bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_we, bus.mdr_we,
                bus.rf_we, bus.pc_we, bus.pc_sel, bus.retire, bus.busy, bus.trap};
    endfunction

    task automatic plan(input int i, input logic r, input logic rd, input logic bt,
                        input logic clr, input logic [2:0] st, input logic [10:0] o);
        pl_run[i] = r;  pl_rdy[i] = rd; pl_brt[i] = bt; pl_clr[i] = clr;
        exp_st[i] = st; exp_o[i]  = o;
    endtask

    // Replays n planned cycles: inputs applied 1 time unit after each rising
    // edge, outputs captured one unit later (well before the next edge).
    task automatic drive(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.run        = pl_run[i];
            bus.mem_ready  = pl_rdy[i];
            bus.br_taken   = pl_brt[i];
            bus.clear_trap = pl_clr[i];
            #1;
            obs_st[i]  = bus.state;
            obs_o[i]   = outs();
            obs_cnt[i] = bus.instret;
            obs_err[i] = bus.err_code;
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bus.run = 1'b0; bus.opcode = 7'd0; bus.br_taken = 1'b0;
        bus.mem_ready = 1'b0; bus.clear_trap = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.state !== IDLE) $display("FAIL reset state: got %0d expected %0d", bus.state, IDLE); else passed++;
        checks++; if (outs() !== O_NONE) $display("FAIL reset strobes: got %b expected %b", outs(), O_NONE); else passed++;
        checks++; if (bus.instret !== 4'd0) $display("FAIL reset instret: got %0d expected 0", bus.instret); else passed++;
        checks++; if (bus.err_code !== 2'd0) $display("FAIL reset err_code: got %0d expected 0", bus.err_code); else passed++;
        rst = 1'b0;
    endtask

    // ADD with zero-wait memory, back to back, then run dropped mid-instruction.
    task automatic test_add();
        bus.opcode = OP_R; bus.mem_ready = 1'b1; bus.run = 1'b1;
        plan(0, 1, 1, 0, 0, FETCH,  O_FETCH_RDY);
        plan(1, 1, 1, 0, 0, DECODE, O_BUSY);
        plan(2, 1, 1, 0, 0, EXEC,   O_BUSY);
        plan(3, 1, 1, 0, 0, WB,     O_WB);
        plan(4, 0, 1, 0, 0, FETCH,  O_FETCH_RDY);
        plan(5, 0, 1, 0, 0, DECODE, O_BUSY);
        plan(6, 0, 1, 0, 0, EXEC,   O_BUSY);
        plan(7, 0, 1, 0, 0, WB,     O_WB);
        plan(8, 0, 1, 0, 0, IDLE,   O_NONE);
        drive(9);
        for (int i = 0; i < 9; i++) begin
            checks++; if (obs_st[i] !== exp_st[i]) $display("FAIL add cyc%0d state: got %0d expected %0d", i, obs_st[i], exp_st[i]); else passed++;
            checks++; if (obs_o[i] !== exp_o[i]) $display("FAIL add cyc%0d strobes: got %b expected %b", i, obs_o[i], exp_o[i]); else passed++;
        end
        checks++; if (obs_cnt[4] !== 4'd1) $display("FAIL add instret first: got %0d expected 1", obs_cnt[4]); else passed++;
        checks++; if (obs_cnt[8] !== 4'd2) $display("FAIL add instret second: got %0d expected 2", obs_cnt[8]); else passed++;
    endtask

    // LOAD with mem_ready held off for 3 MEM cycles: 8 cycles total.
    task automatic test_load();
        bus.opcode = OP_LOAD; bus.run = 1'b1;
        plan(0, 0, 1, 0, 0, FETCH,  O_FETCH_RDY);
        plan(1, 0, 0, 0, 0, DECODE, O_BUSY);
        plan(2, 0, 0, 0, 0, EXEC,   O_BUSY);
        plan(3, 0, 0, 0, 0, MEM,    O_MEM_LD_WAIT);
        plan(4, 0, 0, 0, 0, MEM,    O_MEM_LD_WAIT);
        plan(5, 0, 0, 0, 0, MEM,    O_MEM_LD_WAIT);
        plan(6, 0, 1, 0, 0, MEM,    O_MEM_LD_RDY);
        plan(7, 0, 0, 0, 0, WB,     O_WB);
        plan(8, 0, 0, 0, 0, IDLE,   O_NONE);
        drive(9);
        for (int i = 0; i < 9; i++) begin
            checks++; if (obs_st[i] !== exp_st[i]) $display("FAIL load cyc%0d state: got %0d expected %0d", i, obs_st[i], exp_st[i]); else passed++;
            checks++; if (obs_o[i] !== exp_o[i]) $display("FAIL load cyc%0d strobes: got %b expected %b", i, obs_o[i], exp_o[i]); else passed++;
        end
        checks++; if (obs_cnt[8] !== 4'd3) $display("FAIL load instret: got %0d expected 3", obs_cnt[8]); else passed++;
    endtask

    // Two branches back to back: taken, then not taken; 3 cycles each.
    task automatic test_back_to_back_branch();
        bus.opcode = OP_BRANCH; bus.run = 1'b1;
        plan(0, 1, 1, 0, 0, FETCH,  O_FETCH_RDY);
        plan(1, 1, 1, 0, 0, DECODE, O_BUSY);
        plan(2, 1, 1, 1, 0, EXEC,   O_BR_T);
        plan(3, 0, 1, 0, 0, FETCH,  O_FETCH_RDY);
        plan(4, 0, 1, 0, 0, DECODE, O_BUSY);
        plan(5, 0, 1, 0, 0, EXEC,   O_BR_N);
        plan(6, 0, 1, 0, 0, IDLE,   O_NONE);
        drive(7);
        for (int i = 0; i < 7; i++) begin
            checks++; if (obs_st[i] !== exp_st[i]) $display("FAIL branch cyc%0d state: got %0d expected %0d", i, obs_st[i], exp_st[i]); else passed++;
            checks++; if (obs_o[i] !== exp_o[i]) $display("FAIL branch cyc%0d strobes: got %b expected %b", i, obs_o[i], exp_o[i]); else passed++;
        end
        checks++; if (obs_cnt[3] !== 4'd4) $display("FAIL branch instret first: got %0d expected 4", obs_cnt[3]); else passed++;
        checks++; if (obs_cnt[6] !== 4'd5) $display("FAIL branch instret second: got %0d expected 5", obs_cnt[6]); else passed++;
    endtask

    // mem_ready stuck low in FETCH: 16 request cycles, then TRAP; run ignored
    // in TRAP; clear_trap returns to IDLE and clears err_code.
    task automatic test_timeout();
        bus.opcode = OP_R; bus.run = 1'b1;
        for (int i = 0; i < 16; i++) plan(i, 0, 0, 0, 0, FETCH, O_FETCH_WAIT);
        plan(16, 1, 0, 0, 0, TRAP, O_TRAP);
        plan(17, 1, 0, 0, 1, TRAP, O_TRAP);
        plan(18, 0, 0, 0, 0, IDLE, O_NONE);
        drive(19);
        for (int i = 0; i < 19; i++) begin
            checks++; if (obs_st[i] !== exp_st[i]) $display("FAIL timeout cyc%0d state: got %0d expected %0d", i, obs_st[i], exp_st[i]); else passed++;
            checks++; if (obs_o[i] !== exp_o[i]) $display("FAIL timeout cyc%0d strobes: got %b expected %b", i, obs_o[i], exp_o[i]); else passed++;
        end
        checks++; if (obs_err[15] !== 2'd0) $display("FAIL timeout err before limit: got %0d expected 0", obs_err[15]); else passed++;
        checks++; if (obs_err[16] !== 2'd1) $display("FAIL timeout err in trap: got %0d expected 1", obs_err[16]); else passed++;
        checks++; if (obs_err[17] !== 2'd1) $display("FAIL timeout err sticky: got %0d expected 1", obs_err[17]); else passed++;
        checks++; if (obs_err[18] !== 2'd0) $display("FAIL timeout err cleared: got %0d expected 0", obs_err[18]); else passed++;
        checks++; if (obs_cnt[18] !== 4'd5) $display("FAIL timeout instret: got %0d expected 5", obs_cnt[18]); else passed++;
    endtask

    // Illegal opcode trap, then a STORE whose run drops mid-instruction.
    task automatic test_illegal_store();
        bus.opcode = OP_BAD; bus.run = 1'b1;
        plan(0, 0, 1, 0, 0, FETCH,  O_FETCH_RDY);
        plan(1, 0, 0, 0, 0, DECODE, O_BUSY);
        plan(2, 0, 0, 0, 1, TRAP,   O_TRAP);
        plan(3, 0, 0, 0, 0, IDLE,   O_NONE);
        drive(4);
        for (int i = 0; i < 4; i++) begin
            checks++; if (obs_st[i] !== exp_st[i]) $display("FAIL illegal cyc%0d state: got %0d expected %0d", i, obs_st[i], exp_st[i]); else passed++;
            checks++; if (obs_o[i] !== exp_o[i]) $display("FAIL illegal cyc%0d strobes: got %b expected %b", i, obs_o[i], exp_o[i]); else passed++;
        end
        checks++; if (obs_err[2] !== 2'd2) $display("FAIL illegal err: got %0d expected 2", obs_err[2]); else passed++;
        checks++; if (obs_err[3] !== 2'd0) $display("FAIL illegal err cleared: got %0d expected 0", obs_err[3]); else passed++;
        checks++; if (obs_cnt[3] !== 4'd5) $display("FAIL illegal instret: got %0d expected 5", obs_cnt[3]); else passed++;

        bus.opcode = OP_STORE; bus.run = 1'b1;
        plan(0, 1, 1, 0, 0, FETCH,  O_FETCH_RDY);
        plan(1, 1, 0, 0, 0, DECODE, O_BUSY);
        plan(2, 0, 0, 0, 0, EXEC,   O_BUSY);
        plan(3, 0, 0, 0, 0, MEM,    O_MEM_ST_WAIT);
        plan(4, 0, 0, 0, 0, MEM,    O_MEM_ST_WAIT);
        plan(5, 0, 1, 0, 0, MEM,    O_MEM_ST_RDY);
        plan(6, 0, 0, 0, 0, IDLE,   O_NONE);
        drive(7);
        for (int i = 0; i < 7; i++) begin
            checks++; if (obs_st[i] !== exp_st[i]) $display("FAIL store cyc%0d state: got %0d expected %0d", i, obs_st[i], exp_st[i]); else passed++;
            checks++; if (obs_o[i] !== exp_o[i]) $display("FAIL store cyc%0d strobes: got %b expected %b", i, obs_o[i], exp_o[i]); else passed++;
        end
        checks++; if (obs_cnt[6] !== 4'd6) $display("FAIL store instret: got %0d expected 6", obs_cnt[6]); else passed++;
    endtask

    // Nine more branches bring instret to 15; the next retire wraps to 0.
    task automatic test_instret_wrap();
        bus.opcode = OP_BRANCH; bus.mem_ready = 1'b1; bus.br_taken = 1'b0; bus.run = 1'b1;
        for (int k = 0; k < 9; k++) begin
            repeat (3) tick();
            bus.run = (k < 8);
        end
        tick();
        checks++; if (bus.state !== IDLE) $display("FAIL wrap preload state: got %0d expected %0d", bus.state, IDLE); else passed++;
        checks++; if (bus.instret !== 4'd15) $display("FAIL wrap preload instret: got %0d expected 15", bus.instret); else passed++;
        bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        tick();
        tick();
        checks++; if (bus.retire !== 1'b1) $display("FAIL wrap retire: got %0d expected 1", bus.retire); else passed++;
        tick();
        checks++; if (bus.instret !== 4'd0) $display("FAIL wrap instret: got %0d expected 0", bus.instret); else passed++;
        checks++; if (bus.state !== IDLE) $display("FAIL wrap state: got %0d expected %0d", bus.state, IDLE); else passed++;
    endtask

    // Async reset asserted while a LOAD waits in MEM.
    task automatic test_reset_mid_mem();
        bus.opcode = OP_LOAD; bus.mem_ready = 1'b1; bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        tick();
        bus.mem_ready = 1'b0;
        tick();
        tick();
        #1;
        checks++; if (bus.state !== MEM) $display("FAIL rstmem pre state: got %0d expected %0d", bus.state, MEM); else passed++;
        checks++; if (outs() !== O_MEM_LD_WAIT) $display("FAIL rstmem pre strobes: got %b expected %b", outs(), O_MEM_LD_WAIT); else passed++;
        #1 rst = 1'b1;
        #1;
        checks++; if (bus.state !== IDLE) $display("FAIL rstmem state: got %0d expected %0d", bus.state, IDLE); else passed++;
        checks++; if (outs() !== O_NONE) $display("FAIL rstmem strobes: got %b expected %b", outs(), O_NONE); else passed++;
        bus.mem_ready = 1'b1; bus.run = 1'b1;
        #1;
        checks++; if (outs() !== O_NONE) $display("FAIL rstmem strobes ready: got %b expected %b", outs(), O_NONE); else passed++;
        tick();
        checks++; if (bus.state !== IDLE) $display("FAIL rstmem held state: got %0d expected %0d", bus.state, IDLE); else passed++;
        bus.run = 1'b0; bus.mem_ready = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_load();
        test_back_to_back_branch();
        test_timeout();
        test_illegal_store();
        test_instret_wrap();
        test_reset_mid_mem();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_seq.md
Name: multicycle_seq

Overview:
- Multi-cycle sequencer for the RV32I core. It steps the shared datapath through FETCH, DECODE, EXEC, MEM and WB one phase at a time, so instruction fetch and load/store share a single memory port.
- Its enables gate the per-instruction control decoder: PC/IR/MDR write enables, register-file write, memory request and address mux.
- Adds a memory-handshake timeout, an illegal-opcode trap and a retired-instruction counter.

Parameters:
- TIMEOUT, 16: max cycles mem_req may wait for mem_ready before trapping; 0 disables the timeout.
- INSTRET_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level; permits starting/continuing execution; sampled at instruction boundaries.
- opcode  in  7  IR[6:0]; valid from the DECODE cycle onward.
- br_taken  in  1  branch outcome from the control decoder; valid in EXEC.
- mem_ready  in  1  memory completes the current request this cycle.
- clear_trap  in  1  leaves TRAP.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  write qualifier for mem_req (store only).
- addr_sel  out  1  0 = PC, 1 = ALU result drives the memory address.
- ir_we  out  1  IR load strobe.
- mdr_we  out  1  MDR load strobe (load data).
- rf_we  out  1  register-file write strobe.
- pc_we  out  1  PC update strobe.
- pc_sel  out  1  0 = PC+4, 1 = branch target.
- retire  out  1  one-cycle pulse per completed instruction.
- busy  out  1  state not IDLE and not TRAP.
- trap  out  1  state is TRAP.
- err_code  out  2  0 = none, 1 = memory timeout, 2 = illegal opcode; sticky until clear_trap.
- state  out  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=7.
- instret  out  INSTRET_W  retired-instruction count.

Behaviour:
- Reset (async): state=IDLE, err_code=0, instret=0, class register=0, timeout count=0. Every strobe and mem_req/mem_we/addr_sel/pc_sel/retire/busy/trap is 0.
- Outputs decode combinationally from the state register plus mem_ready (Mealy strobes). All registers update on the clk rising edge.
- IDLE: run=1 -> FETCH; otherwise stay.
- FETCH: mem_req=1, mem_we=0, addr_sel=0.
  - On mem_ready: ir_we=1 that cycle -> DECODE.
  - Else count++. When count reaches TIMEOUT (TIMEOUT>0) -> TRAP, err_code=1.
- DECODE: one cycle. Latch opcode class: R=0110011, I=0010011, LOAD=0000011, STORE=0100011, LUI=0110111, BRANCH=1100011.
  - Any other opcode -> TRAP, err_code=2.
  - Otherwise -> EXEC.
- EXEC: one cycle, using the latched class.
  - BRANCH: pc_we=1, pc_sel=br_taken, retire=1; go to boundary.
  - LOAD/STORE -> MEM.
  - R/I/LUI -> WB.
- MEM: mem_req=1, addr_sel=1, mem_we=(class==STORE).
  - On mem_ready, STORE: pc_we=1, pc_sel=0, retire=1; go to boundary.
  - On mem_ready, LOAD: mdr_we=1 -> WB.
  - Timeout behaves as in FETCH.
- WB: rf_we=1, pc_we=1, pc_sel=0, retire=1; go to boundary.
- Boundary: run=1 -> FETCH, run=0 -> IDLE. A mid-instruction run drop never aborts the instruction.
- Timeout counter clears on entry to FETCH/MEM and on mem_ready. If mem_ready and the timeout limit coincide, mem_ready wins.
- mem_req is never withdrawn before mem_ready except on timeout entry to TRAP. Address and mem_we are stable while mem_req=1.
- TRAP: all strobes 0. clear_trap=1 -> IDLE, err_code=0. run has no effect in TRAP.
- instret increments on each retire and wraps modulo 2^INSTRET_W.
- Async reset mid-instruction: return to IDLE immediately. No strobe is asserted while rst=1.
- Latencies with zero-wait memory (mem_ready=1 on first request cycle):
  - R/I/LUI: 4 cycles.
  - BRANCH: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.

Test Plan:
- Reset, run=1, opcode=0110011 (ADD), mem_ready always 1 -> states 1,2,3,5,1. rf_we and retire pulse in cycle 4. instret=1 after one instruction.
- LOAD (0000011) with mem_ready delayed 3 cycles in MEM -> mem_req=1, addr_sel=1, mem_we=0 held 4 cycles. mdr_we pulses with mem_ready, then WB rf_we=1. Total 8 cycles.
- BRANCH (1100011), br_taken=1 then br_taken=0 -> pc_we=1 in EXEC with pc_sel=1 then 0. rf_we stays 0. Each branch takes 3 cycles.
- TIMEOUT=16, mem_ready stuck 0 in FETCH -> after 16 request cycles state=7, err_code=1, mem_req=0. clear_trap -> IDLE, err_code=0.
- opcode=1111111 -> DECODE -> TRAP, err_code=2, instret unchanged. Then run=0 during a STORE's MEM wait -> the store completes (pc_we, retire) and the sequencer goes IDLE.
- instret preloaded via 2^INSTRET_W-1 retires (INSTRET_W=4: 15) -> next retire wraps to 0. Assert rst mid-MEM -> state=0 and all outputs 0 immediately.
